// File: rtl/order_pkg.sv
// Shared types and constants for the order message packer.
// Holds order/trade/stock enums, type bytes and stock ASCII codes.
package order_pkg;

    typedef enum logic [1:0] {
        ORD_ADD     = 2'd0,
        ORD_CANCEL  = 2'd1,
        ORD_EXECUTE = 2'd2,
        ORD_ILLEGAL = 2'd3
    } order_t;

    typedef enum logic {
        TRADE_BUY  = 1'b0,
        TRADE_SELL = 1'b1
    } trade_t;

    typedef enum logic [1:0] {
        STOCK_AAPL  = 2'd0,
        STOCK_AMZN  = 2'd1,
        STOCK_GOOGL = 2'd2,
        STOCK_MSFT  = 2'd3
    } stock_t;

    localparam logic [7:0] TYPE_BYTE_ADD     = 8'h41;
    localparam logic [7:0] TYPE_BYTE_CANCEL  = 8'h58;
    localparam logic [7:0] TYPE_BYTE_EXECUTE = 8'h45;

    localparam logic [63:0] SYM_AAPL  = 64'h4141504C20202020;
    localparam logic [63:0] SYM_AMZN  = 64'h414D5A4E20202020;
    localparam logic [63:0] SYM_GOOGL = 64'h474F4F474C202020;
    localparam logic [63:0] SYM_MSFT  = 64'h4D53465420202020;

    localparam int PAYLOAD_WORDS = 9;

    function automatic logic [7:0] type_byte(input order_t t);
        logic [7:0] b;
        b = 8'h00;
        unique case (t)
            ORD_ADD:     b = TYPE_BYTE_ADD;
            ORD_CANCEL:  b = TYPE_BYTE_CANCEL;
            ORD_EXECUTE: b = TYPE_BYTE_EXECUTE;
            default:     b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/stock_sym_encoder.sv
// Stock symbol to 64-bit space-padded ASCII code.
// Purely combinational lookup.
module stock_sym_encoder
    import order_pkg::*;
(
    input  stock_t      stock,
    output logic [63:0] sym
);

    // select the ASCII code for the registered stock
    always_comb begin
        sym = SYM_AAPL;
        unique case (stock)
            STOCK_AAPL:  sym = SYM_AAPL;
            STOCK_AMZN:  sym = SYM_AMZN;
            STOCK_GOOGL: sym = SYM_GOOGL;
            STOCK_MSFT:  sym = SYM_MSFT;
            default:     sym = SYM_AAPL;
        endcase
    end

endmodule

// File: rtl/order_msg_packer.sv
// Packs one order into a stream of fixed-layout message words.
// Optional checksum word enabled by ORDER_PACKER_CHECKSUM_EN.
module order_msg_packer
    import order_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int NUM_WORDS = 9
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_order_type,
    input  logic [1:0]           i_stock_symbol,
    input  logic [REG_WIDTH-1:0] i_order_id,
    input  logic [REG_WIDTH-1:0] i_price,
    input  logic [REG_WIDTH-1:0] i_quantity,
    input  logic                 i_trade_type,
    input  logic [63:0]          i_curr_time,
    input  logic [15:0]          i_locate_code,
    input  logic [15:0]          i_tracking_number,
    output logic [REG_WIDTH-1:0] o_word,
    output logic [3:0]           o_word_idx,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic                 o_last,
    output logic                 o_err
);

`ifdef ORDER_PACKER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    localparam logic [3:0] LAST_PAY = 4'(NUM_WORDS - 1);

    state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic err_q, err_d;
    logic load;

    order_t               type_q;
    stock_t               stock_q;
    trade_t               side_q;
    logic [REG_WIDTH-1:0] oid_q;
    logic [REG_WIDTH-1:0] price_q;
    logic [REG_WIDTH-1:0] qty_q;
    logic [47:0]          time_q;
    logic [15:0]          loc_q;
    logic [15:0]          trk_q;

    logic [63:0] sym;
    logic [63:0] oid64;
    logic [31:0] qty32;
    logic [31:0] words [PAYLOAD_WORDS];
    logic [15:0] unused_time;

    assign unused_time = i_curr_time[63:48];
    assign oid64 = 64'(oid_q);
    assign qty32 = 32'(qty_q);

    stock_sym_encoder u_sym (
        .stock (stock_q),
        .sym   (sym)
    );

`ifdef ORDER_PACKER_CHECKSUM_EN
    logic [31:0] chk_word;

    // fold all payload words into the trailing checksum word
    always_comb begin
        chk_word = '0;
        for (int k = 0; k < PAYLOAD_WORDS; k++) begin
            chk_word = chk_word ^ words[k];
        end
    end
`endif

    // lay out the full message from the captured order fields
    always_comb begin
        for (int k = 0; k < PAYLOAD_WORDS; k++) begin
            words[k] = '0;
        end
        words[0] = {trk_q[7:0], loc_q, type_byte(type_q)};
        words[1] = {time_q[23:0], trk_q[15:8]};
        words[2] = {oid64[7:0], time_q[47:24]};
        words[3] = oid64[39:8];
        words[4][23:0] = oid64[63:40];
        unique case (type_q)
            ORD_ADD: begin
                words[4][31:24] = (side_q == TRADE_SELL) ? 8'h01 : 8'h00;
                words[5] = qty32;
                words[6] = sym[31:0];
                words[7] = sym[63:32];
                words[8] = 32'(price_q);
            end
            ORD_CANCEL: begin
                words[4][31:24] = sym[7:0];
                words[5] = sym[39:8];
                words[6][23:0] = sym[63:40];
            end
            ORD_EXECUTE: begin
                words[4][31:24] = qty32[7:0];
                words[5] = {sym[7:0], qty32[31:8]};
                words[6] = sym[39:8];
                words[7][23:0] = sym[63:40];
            end
            default: ;
        endcase
    end

    // next state, word index and output handshake
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_d        = 1'b0;
        load         = 1'b0;
        o_ready      = 1'b0;
        o_word_valid = 1'b0;
        o_last       = 1'b0;
        o_word       = '0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    load = 1'b1;
                    if (i_order_type == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SEND;
                        idx_d   = '0;
                    end
                end
            end
            SEND: begin
                o_word_valid = 1'b1;
                o_word       = REG_WIDTH'(words[idx_q]);
`ifndef ORDER_PACKER_CHECKSUM_EN
                o_last       = (idx_q == LAST_PAY);
`endif
                if (i_word_ready) begin
                    if (idx_q == LAST_PAY) begin
`ifdef ORDER_PACKER_CHECKSUM_EN
                        state_d = CHK;
                        idx_d   = idx_q + 4'd1;
`else
                        state_d = IDLE;
                        idx_d   = '0;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`ifdef ORDER_PACKER_CHECKSUM_EN
            CHK: begin
                o_word_valid = 1'b1;
                o_last       = 1'b1;
                o_word       = REG_WIDTH'(chk_word);
                if (i_word_ready) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign o_word_idx = idx_q;
    assign o_err      = err_q;

    // state register, word index and error pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // capture the order fields at the accepting edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            type_q  <= ORD_ADD;
            stock_q <= STOCK_AAPL;
            side_q  <= TRADE_BUY;
            oid_q   <= '0;
            price_q <= '0;
            qty_q   <= '0;
            time_q  <= '0;
            loc_q   <= '0;
            trk_q   <= '0;
        end else if (load) begin
            type_q  <= order_t'(i_order_type);
            stock_q <= stock_t'(i_stock_symbol);
            side_q  <= trade_t'(i_trade_type);
            oid_q   <= i_order_id;
            price_q <= i_price;
            qty_q   <= i_quantity;
            time_q  <= i_curr_time[47:0];
            loc_q   <= i_locate_code;
            trk_q   <= i_tracking_number;
        end
    end

endmodule

// File: tb/tb_order_msg_packer.sv
// Directed and randomized bench for order_msg_packer.
// Expected words come from a packed-record model of the message.
module tb_order_msg_packer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_order_type = '0;
    logic [1:0]  i_stock_symbol = '0;
    logic [31:0] i_order_id = '0;
    logic [31:0] i_price = '0;
    logic [31:0] i_quantity = '0;
    logic        i_trade_type = 1'b0;
    logic [63:0] i_curr_time = '0;
    logic [15:0] i_locate_code = '0;
    logic [15:0] i_tracking_number = '0;
    logic [31:0] o_word;
    logic [3:0]  o_word_idx;
    logic        o_word_valid;
    logic        i_word_ready = 1'b1;
    logic        o_last;
    logic        o_err;

    int n_assert = 0;
    int n_fail = 0;

    logic [31:0] exp_w [10];
    int          nexp = 0;
    logic [63:0] sym_tab [4] = '{
        64'h4141504C20202020, 64'h414D5A4E20202020,
        64'h474F4F474C202020, 64'h4D53465420202020
    };

    order_msg_packer #(.REG_WIDTH(32), .NUM_WORDS(9)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_order_type      (i_order_type),
        .i_stock_symbol    (i_stock_symbol),
        .i_order_id        (i_order_id),
        .i_price           (i_price),
        .i_quantity        (i_quantity),
        .i_trade_type      (i_trade_type),
        .i_curr_time       (i_curr_time),
        .i_locate_code     (i_locate_code),
        .i_tracking_number (i_tracking_number),
        .o_word            (o_word),
        .o_word_idx        (o_word_idx),
        .o_word_valid      (o_word_valid),
        .i_word_ready      (i_word_ready),
        .o_last            (o_last),
        .o_err             (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // message as one little-endian packed record, cut into 32-bit words
    task automatic build(input logic [1:0] ty, input logic [1:0] sk,
                         input logic [31:0] oid, input logic [31:0] price,
                         input logic [31:0] qty, input logic sd,
                         input logic [63:0] tm, input logic [15:0] loc,
                         input logic [15:0] trk);
        logic [319:0] v;
        logic [151:0] hdr;
        logic [7:0]   tb;
        logic [63:0]  sym;
        logic [31:0]  x;
        sym = sym_tab[sk];
        tb = (ty == 2'd0) ? 8'h41 : (ty == 2'd1) ? 8'h58 : 8'h45;
        hdr = {64'(oid), tm[47:0], trk, loc, tb};
        if (ty == 2'd0)
            v = 320'({price, sym, qty, 7'd0, sd, hdr});
        else if (ty == 2'd1)
            v = 320'({sym, hdr});
        else
            v = 320'({sym, qty, hdr});
        x = '0;
        for (int k = 0; k < 9; k++) begin
            exp_w[k] = v[32*k +: 32];
            x = x ^ exp_w[k];
        end
        nexp = 9;
`ifdef ORDER_PACKER_CHECKSUM_EN
        exp_w[9] = x;
        nexp = 10;
`endif
    endtask

    task automatic send(input logic [1:0] ty, input logic [1:0] sk,
                        input logic [31:0] oid, input logic [31:0] price,
                        input logic [31:0] qty, input logic sd,
                        input logic [63:0] tm, input logic [15:0] loc,
                        input logic [15:0] trk);
        int w = 0;
        while (o_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_send", 64'(o_ready), 64'd1);
        i_order_type = ty;
        i_stock_symbol = sk;
        i_order_id = oid;
        i_price = price;
        i_quantity = qty;
        i_trade_type = sd;
        i_curr_time = tm;
        i_locate_code = loc;
        i_tracking_number = trk;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_order_type = 2'($urandom);
        i_stock_symbol = 2'($urandom);
        i_order_id = $urandom;
        i_price = $urandom;
        i_quantity = $urandom;
        i_trade_type = 1'($urandom);
        i_curr_time = {$urandom, $urandom};
        i_locate_code = 16'($urandom);
        i_tracking_number = 16'($urandom);
        if (ty != 2'd3)
            build(ty, sk, oid, price, qty, sd, tm, loc, trk);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles at w3
    task automatic recv(input int mode, input int stop);
        int k = 0;
        int cyc = 0;
        int st = 0;
        logic rdy;
        while (k < stop && cyc < 300) begin
            if (mode == 1)
                rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 2)
                rdy = !(k == 3 && st < 5);
            else
                rdy = 1'b1;
            i_word_ready = rdy;
            chk($sformatf("valid_w%0d", k), 64'(o_word_valid), 64'd1);
            chk($sformatf("idx_w%0d", k), 64'(o_word_idx), 64'(k));
            chk($sformatf("word_w%0d", k), 64'(o_word), 64'(exp_w[k]));
            chk($sformatf("last_w%0d", k), 64'(o_last), 64'(k == nexp - 1));
            if (!rdy) st++;
            tick();
            if (rdy) k++;
            cyc++;
        end
        i_word_ready = 1'b1;
        chk("recv_complete", 64'(k), 64'(stop));
        if (stop == nexp) begin
            chk("idle_valid", 64'(o_word_valid), 64'd0);
            chk("idle_ready", 64'(o_ready), 64'd1);
            chk("idle_last", 64'(o_last), 64'd0);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        chk("rst_valid", 64'(o_word_valid), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_word", 64'(o_word), 64'd0);
        chk("rst_idx", 64'(o_word_idx), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);

        send(2'd0, 2'd0, 32'h12345678, 32'h64, 32'h0A, 1'b1,
             64'h010203, 16'h0007, 16'h0102);
        recv(0, nexp);

        send(2'd1, 2'd3, 32'h1, $urandom, $urandom, 1'($urandom),
             {$urandom, $urandom}, 16'($urandom), 16'($urandom));
        recv(0, nexp);

        send(2'd2, 2'd2, $urandom, $urandom, 32'h11223344, 1'($urandom),
             {$urandom, $urandom}, 16'($urandom), 16'($urandom));
        recv(0, nexp);

        send(2'd0, 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
             {$urandom, $urandom}, 16'($urandom), 16'($urandom));
        recv(2, nexp);

        send(2'd3, 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
             {$urandom, $urandom}, 16'($urandom), 16'($urandom));
        chk("err_pulse", 64'(o_err), 64'd1);
        chk("err_no_valid", 64'(o_word_valid), 64'd0);
        tick();
        chk("err_cleared", 64'(o_err), 64'd0);
        chk("err_ready_next", 64'(o_ready), 64'd1);
        chk("err_no_valid_next", 64'(o_word_valid), 64'd0);

        send(2'd0, 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
             {$urandom, $urandom}, 16'($urandom), 16'($urandom));
        recv(0, 5);
        chk("pre_reset_idx", 64'(o_word_idx), 64'd5);
        i_reset = 1'b1;
        i_valid = 1'b1;
        i_order_type = 2'd0;
        tick();
        chk("mid_rst_valid", 64'(o_word_valid), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        tick();
        i_reset = 1'b0;
        i_valid = 1'b0;
        chk("rst_ignore_valid", 64'(o_word_valid), 64'd0);
        chk("rst_ignore_idx", 64'(o_word_idx), 64'd0);
        tick();
        chk("post_rst_valid", 64'(o_word_valid), 64'd0);
        chk("post_rst_ready", 64'(o_ready), 64'd1);
        send(2'd2, 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
             {$urandom, $urandom}, 16'($urandom), 16'($urandom));
        recv(0, nexp);

        for (int i = 0; i < 8; i++) begin
            send(2'($urandom_range(0, 2)), 2'($urandom), $urandom, $urandom,
                 $urandom, 1'($urandom), {$urandom, $urandom},
                 16'($urandom), 16'($urandom));
            recv(1, nexp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
